// File: rtl/pe1x1_acc_if.sv
// rtl/pe1x1_acc_if.sv - beat/result handshake bundle for the 1x1 conv processing element
interface pe1x1_acc_if #(
  parameter int LANES = 7,
  parameter int W     = 32,
  parameter int CW    = 7
);
  logic [CW-1:0]      cfg_cin;
  logic               cfg_relu;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] fmap_i;
  logic [W-1:0]       wht_i;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] res_o;
  logic               busy;

  modport slave (
    input  cfg_cin, cfg_relu, in_valid, fmap_i, wht_i, out_ready,
    output in_ready, out_valid, res_o, busy
  );

  modport master (
    output cfg_cin, cfg_relu, in_valid, fmap_i, wht_i, out_ready,
    input  in_ready, out_valid, res_o, busy
  );
endinterface

// File: rtl/pe1x1_acc.sv
// rtl/pe1x1_acc.sv - 1x1 conv PE: per-lane MAC over input channels, saturated/ReLU result register
module pe1x1_acc #(
  parameter int LANES   = 7,
  parameter int IW      = 24,
  parameter int FW      = 8,
  parameter int GW      = 8,
  parameter int CIN_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  pe1x1_acc_if.slave  bus
);
  localparam int W  = IW + FW;
  localparam int AW = W + GW;
  localparam int CW = $clog2(CIN_MAX + 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            cin_q, cin_d;
  logic                     relu_q, relu_d;
  logic [LANES-1:0][AW-1:0] acc_q, acc_d;
  logic [LANES*W-1:0]       res_q, res_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [2*W-1:0]    prod_full [LANES];
  logic signed [2*W-1:0]    prod_sh   [LANES];
  logic [LANES-1:0][AW-1:0] prod;
  logic [LANES-1:0][AW-1:0] sum;
  logic [LANES*W-1:0]       res_fin;
  logic [W-1:0]             sat_w;
  logic [GW:0]              upper;
  logic [CW-1:0]            cin_cfg;
  logic                     relu_eff;
  logic                     accept;
  logic                     last;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.res_o     = res_q;
  assign bus.busy      = (state_q == ACC) || out_valid_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign cin_cfg  = (bus.cfg_cin == '0)             ? CW'(1) :
                    (bus.cfg_cin > CW'(CIN_MAX))    ? CW'(CIN_MAX) : bus.cfg_cin;
  assign relu_eff = (state_q == IDLE) ? bus.cfg_relu : relu_q;
  assign last     = accept && ((state_q == IDLE) ? (cin_cfg == CW'(1))
                                                 : (cnt_q + CW'(1) == cin_q));

  // Lanes share one weight; the first beat of a group starts from zero instead of acc_q.
  always_comb begin
    res_fin = '0;
    sat_w   = '0;
    upper   = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_full[k] = $signed(bus.fmap_i[k*W +: W]) * $signed(bus.wht_i);
      prod_sh[k]   = prod_full[k] >>> FW;
      prod[k]      = prod_sh[k][AW-1:0];
      sum[k]       = ((state_q == IDLE) ? '0 : acc_q[k]) + prod[k];
      upper        = sum[k][AW-1:W-1];
      if ((&upper) || !(|upper)) begin
        sat_w = sum[k][W-1:0];
      end else if (sum[k][AW-1]) begin
        sat_w = {1'b1, {(W-1){1'b0}}};
      end else begin
        sat_w = {1'b0, {(W-1){1'b1}}};
      end
      if (relu_eff && sat_w[W-1]) begin
        sat_w = '0;
      end
      res_fin[k*W +: W] = sat_w;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cin_d       = cin_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (accept) begin
      acc_d = sum;
      if (state_q == IDLE) begin
        cin_d  = cin_cfg;
        relu_d = bus.cfg_relu;
        cnt_d  = CW'(1);
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
      if (last) begin
        state_d     = IDLE;
        cnt_d       = '0;
        res_d       = res_fin;
        out_valid_d = 1'b1;
      end else begin
        state_d     = ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cin_q       <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cin_q       <= cin_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_pe1x1_acc.sv
// tb/tb_pe1x1_acc.sv - directed self-checking bench for pe1x1_acc
module tb_pe1x1_acc;
  localparam int LANES = 7;
  localparam int W     = 32;
  localparam int CW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pe1x1_acc_if #(.LANES(LANES), .W(W), .CW(CW)) bus ();

  pe1x1_acc #(.LANES(LANES), .IW(24), .FW(8), .GW(8), .CIN_MAX(64)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [LANES*W-1:0] rep(input logic [W-1:0] v);
    logic [LANES*W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*W +: W] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cin, input logic relu, input logic [LANES*W-1:0] f,
                       input logic [W-1:0] w);
    bus.cfg_cin  = CW'(cin);
    bus.cfg_relu = relu;
    bus.fmap_i   = f;
    bus.wht_i    = w;
    bus.in_valid = 1'b1;
  endtask

  logic [LANES*W-1:0] ramp;

  initial begin
    bus.cfg_cin   = '0;
    bus.cfg_relu  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fmap_i    = '0;
    bus.wht_i     = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) ramp[k*W +: W] = W'(k << 8);
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_res", bus.res_o, 0);
    step();
    rst = 1'b0;

    // cin=1: 1.0 * 2.0
    drive(1, 1'b0, rep(32'h0000_0100), 32'h0000_0200);
    step();
    bus.in_valid = 1'b0;
    chk("c1_valid", bus.out_valid, 1);
    chk("c1_res", bus.res_o, rep(32'h0000_0200));
    step();
    chk("c1_consumed", bus.out_valid, 0);

    // cfg_cin=0 behaves as a single-beat group
    drive(0, 1'b0, rep(32'h0000_0300), 32'h0000_0100);
    step();
    bus.in_valid = 1'b0;
    chk("c0_valid", bus.out_valid, 1);
    chk("c0_res", bus.res_o, rep(32'h0000_0300));
    step();

    // cin=4 ramp * 0.5; cfg changes after beat 1 must be ignored
    drive(4, 1'b0, ramp, 32'h0000_0080);
    for (int b = 0; b < 3; b++) begin
      step();
      bus.cfg_cin  = CW'(1);
      bus.cfg_relu = 1'b1;
      chk("c4_novalid", bus.out_valid, 0);
      chk("c4_busy", bus.busy, 1);
    end
    step();
    bus.in_valid = 1'b0;
    chk("c4_valid", bus.out_valid, 1);
    for (int k = 0; k < LANES; k++) ramp[k*W +: W] = W'(k << 9);
    chk("c4_res", bus.res_o, ramp);
    chk("c4_busy_pend", bus.busy, 1);
    step();
    chk("c4_busy_done", bus.busy, 0);

    // -1.0 * 3.0 twice, relu off then on
    drive(2, 1'b0, rep(32'hFFFF_FF00), 32'h0000_0300);
    step();
    bus.cfg_relu = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("neg_res", bus.res_o, rep(32'hFFFF_FA00));
    step();
    drive(2, 1'b1, rep(32'hFFFF_FF00), 32'h0000_0300);
    step();
    bus.cfg_relu = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("relu_valid", bus.out_valid, 1);
    chk("relu_res", bus.res_o, rep(32'h0000_0000));
    step();

    // saturation both directions
    drive(2, 1'b0, rep(32'h4000_0000), 32'h0000_0400);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("sat_pos", bus.res_o, rep(32'h7FFF_FFFF));
    step();
    drive(2, 1'b0, rep(32'hC000_0000), 32'h0000_0400);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("sat_neg", bus.res_o, rep(32'h8000_0000));
    step();

    // backpressure: second group stalls until the first result is taken
    bus.out_ready = 1'b0;
    drive(2, 1'b0, rep(32'h0000_0100), 32'h0000_0100);
    step();
    step();
    drive(2, 1'b0, rep(32'h0000_0200), 32'h0000_0100);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_res_a", bus.res_o, rep(32'h0000_0200));
    step();
    step();
    chk("bp_hold_valid", bus.out_valid, 1);
    chk("bp_hold_res", bus.res_o, rep(32'h0000_0200));
    chk("bp_hold_busy", bus.busy, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    chk("bp_consumed", bus.out_valid, 0);
    chk("bp_b_open", bus.busy, 1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_b_valid", bus.out_valid, 1);
    chk("bp_b_res", bus.res_o, rep(32'h0000_0400));
    step();

    // asynchronous reset mid-group, then a clean group
    drive(4, 1'b0, rep(32'h0000_0500), 32'h0000_0100);
    step();
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_res", bus.res_o, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    step();
    rst = 1'b0;
    drive(1, 1'b0, rep(32'h0000_0100), 32'h0000_0100);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_res", bus.res_o, rep(32'h0000_0100));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
